// File: rtl/sram_axi4_rd_master.sv
// AXI4 read master: one request -> one AR burst -> R beats through a 1-entry buffer -> valid/ready stream, then o_done/o_err.
// Request to first data 3 cycles, 1 beat/cycle sustained, R stalls on a full undrained buffer; watchdog under SRAM_AXI4_RD_MASTER_TIMEOUT_EN.
module sram_axi4_rd_master #(
  parameter int              ID_W    = 4,
  parameter logic [ID_W-1:0] REQ_ID  = ID_W'(1),
  parameter int              TIMEOUT = 255
) (
  input  logic            i_aclk,
  input  logic            i_areset_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [7:0]      i_req_addr,
  input  logic [7:0]      i_req_len,
  input  logic [1:0]      i_req_burst,
  output logic            o_dat_valid,
  input  logic            i_dat_ready,
  output logic [63:0]     o_dat_data,
  output logic            o_dat_last,
  output logic            o_done,
  output logic [2:0]      o_err,
  output logic            o_busy,
  output logic [ID_W-1:0] o_arid,
  output logic [7:0]      o_araddr,
  output logic [7:0]      o_arlen,
  output logic [2:0]      o_arsize,
  output logic [1:0]      o_arburst,
  output logic [1:0]      o_arlock,
  output logic [3:0]      o_arcache,
  output logic [2:0]      o_arprot,
  output logic [3:0]      o_arqos,
  output logic [3:0]      o_arregion,
  output logic [ID_W-1:0] o_aruser,
  output logic            o_arvalid,
  input  logic            i_arready,
  output logic            o_rready,
  input  logic [ID_W-1:0] i_rid,
  input  logic [63:0]     i_rdata,
  input  logic [1:0]      i_rresp,
  input  logic            i_rlast,
  input  logic [ID_W-1:0] i_ruser,
  input  logic            i_rvalid
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e      state_q;
  logic        req_rdy_q, arvalid_q, done_q, buf_vld_q, buf_last_q;
  logic [7:0]  addr_q, len_q, cnt_q;
  logic [1:0]  burst_q;
  logic [2:0]  err_q;
  logic [63:0] buf_dat_q;
  logic        req_hs, ar_hs, r_hs, out_hs, rready, beat_last, proto_bad, wd_fire;

  assign rready    = (state_q == DATA) && (!buf_vld_q || i_dat_ready);
  assign req_hs    = i_req_valid && req_rdy_q;
  assign ar_hs     = arvalid_q && i_arready;
  assign r_hs      = rready && i_rvalid;
  assign out_hs    = buf_vld_q && i_dat_ready;
  assign beat_last = (cnt_q == len_q);
  assign proto_bad = (i_rlast != beat_last) || (i_rid != REQ_ID);

`ifdef SRAM_AXI4_RD_MASTER_TIMEOUT_EN
  logic [7:0] wd_q;

  // Fires so that o_done lands TIMEOUT cycles after the last handshake.
  assign wd_fire = ((state_q == ADDR) || (state_q == DATA)) && !ar_hs && !r_hs &&
                   ((wd_q + 8'd2) == 8'(TIMEOUT));

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wd_q <= '0;
    end else if (req_hs || ar_hs || r_hs || !((state_q == ADDR) || (state_q == DATA))) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 8'd1;
    end
  end
`else
  logic unused_ok;
  assign wd_fire   = 1'b0;
  assign unused_ok = ^{i_ruser, 8'(TIMEOUT)};
`endif

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q    <= IDLE;
      req_rdy_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      done_q     <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_last_q <= 1'b0;
      buf_dat_q  <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      err_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (r_hs) begin
        buf_vld_q  <= 1'b1;
        buf_dat_q  <= i_rdata;
        buf_last_q <= beat_last;
      end else if (out_hs) begin
        buf_vld_q  <= 1'b0;
        buf_last_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          req_rdy_q <= 1'b1;
          if (req_hs) begin
            req_rdy_q <= 1'b0;
            addr_q    <= i_req_addr;
            len_q     <= i_req_len;
            burst_q   <= (i_req_burst == 2'b11) ? 2'b01 : i_req_burst;
            cnt_q     <= '0;
            err_q     <= '0;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (wd_fire) begin
            arvalid_q <= 1'b0;
            err_q[2]  <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (ar_hs) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            err_q <= err_q | {proto_bad, i_rresp};
            if (beat_last) state_q <= DONE;
          end else if (wd_fire) begin
            // Abandon the burst: whatever sits in the buffer is dropped.
            buf_vld_q  <= 1'b0;
            buf_last_q <= 1'b0;
            err_q[2]   <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (done_q) begin
            req_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!buf_vld_q || out_hs) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready = req_rdy_q;
  assign o_dat_valid = buf_vld_q;
  assign o_dat_data  = buf_dat_q;
  assign o_dat_last  = buf_last_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != IDLE);
  assign o_arid      = REQ_ID;
  assign o_araddr    = addr_q;
  assign o_arlen     = len_q;
  assign o_arsize    = 3'b011;
  assign o_arburst   = burst_q;
  assign o_arlock    = '0;
  assign o_arcache   = '0;
  assign o_arprot    = '0;
  assign o_arqos     = '0;
  assign o_arregion  = '0;
  assign o_aruser    = '0;
  assign o_arvalid   = arvalid_q;
  assign o_rready    = rready;

endmodule

// File: tb/tb_sram_axi4_rd_master.sv
// Directed bench for sram_axi4_rd_master: a cycle-stepped AXI slave/consumer model drives the DUT
// at the falling edge and checks handshakes, data order, status and latency against hand-derived values.
module tb_sram_axi4_rd_master;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_req_valid = 1'b0, i_dat_ready = 1'b0, i_arready = 1'b0;
  logic            i_rvalid = 1'b0, i_rlast = 1'b0;
  logic [7:0]      i_req_addr = '0, i_req_len = '0;
  logic [1:0]      i_req_burst = '0, i_rresp = '0;
  logic [63:0]     i_rdata = '0;
  logic [ID_W-1:0] i_rid = 4'h1, i_ruser = '0;
  logic            o_req_ready, o_dat_valid, o_dat_last, o_done, o_busy, o_arvalid, o_rready;
  logic [63:0]     o_dat_data;
  logic [2:0]      o_err, o_arsize, o_arprot;
  logic [ID_W-1:0] o_arid, o_aruser;
  logic [7:0]      o_araddr, o_arlen;
  logic [1:0]      o_arburst, o_arlock;
  logic [3:0]      o_arcache, o_arqos, o_arregion;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_axi4_rd_master #(.ID_W(ID_W), .REQ_ID(4'h1), .TIMEOUT(16)) dut (
    .i_aclk(clk), .i_areset_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .i_req_burst(i_req_burst),
    .o_dat_valid(o_dat_valid), .i_dat_ready(i_dat_ready), .o_dat_data(o_dat_data),
    .o_dat_last(o_dat_last), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache), .o_arprot(o_arprot),
    .o_arqos(o_arqos), .o_arregion(o_arregion), .o_aruser(o_aruser),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_rready(o_rready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_ruser(i_ruser), .i_rvalid(i_rvalid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
    check_eq({tag, "_arvalid"},   64'(o_arvalid),   64'd0);
    check_eq({tag, "_rready"},    64'(o_rready),    64'd0);
    check_eq({tag, "_dat_valid"}, 64'(o_dat_valid), 64'd0);
    check_eq({tag, "_dat_last"},  64'(o_dat_last),  64'd0);
    check_eq({tag, "_done"},      64'(o_done),      64'd0);
    check_eq({tag, "_busy"},      64'(o_busy),      64'd0);
    check_eq({tag, "_err"},       64'(o_err),       64'd0);
    check_eq({tag, "_araddr"},    64'(o_araddr),    64'd0);
    check_eq({tag, "_arlen"},     64'(o_arlen),     64'd0);
  endtask

  // One burst. Inputs are driven at the falling edge; #1 later the outputs are sampled and every
  // handshake that the next rising edge will complete is scored by the model.
  task automatic run_burst(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int ar_delay, input bit toggle, input int resp_beat,
                           input logic [1:0] resp_val, input int early_last, input logic [63:0] base,
                           input int abort_after, input bit chk_timing);
    logic [1:0] exp_burst;
    logic [2:0] exp_err;
    bit req_sent, ar_done, got_done, aborted;
    int ar_seen, k, outcnt;
    int req_cyc, ar_cyc, r0_cyc, out0_cyc, outl_cyc, done_cyc;
    exp_burst = (burst == 2'b11) ? 2'b01 : burst;
    exp_err = 3'b000;
    req_sent = 0; ar_done = 0; got_done = 0; aborted = 0;
    ar_seen = 0; k = 0; outcnt = 0;
    req_cyc = -1; ar_cyc = -1; r0_cyc = -1; out0_cyc = -1; outl_cyc = -1; done_cyc = -1;
    i_req_addr = addr; i_req_len = len; i_req_burst = burst;
    for (int cyc = 0; cyc < 400 && !got_done && !aborted; cyc++) begin
      @(negedge clk);
      i_req_valid = !req_sent;
      i_arready   = (ar_seen >= ar_delay);
      i_rvalid    = ar_done && (k <= int'(len));
      i_rdata     = base + 64'(k);
      i_rresp     = (k == resp_beat) ? resp_val : 2'b00;
      i_rlast     = (k == int'(len)) || (k == early_last);
      i_dat_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (i_req_valid && o_req_ready) begin req_sent = 1; req_cyc = cyc; end
      if (o_arvalid) begin
        check_eq("araddr", 64'(o_araddr), 64'(addr));
        check_eq("arlen", 64'(o_arlen), 64'(len));
        check_eq("arburst", 64'(o_arburst), 64'(exp_burst));
        check_eq("arsize", 64'(o_arsize), 64'd3);
        if (i_arready) begin ar_done = 1; ar_cyc = cyc; end
        else ar_seen++;
      end
      if (toggle && o_dat_valid && !i_dat_ready)
        check_eq("rready_full", 64'(o_rready), 64'd0);
      if (o_dat_valid && i_dat_ready) begin
        check_eq("dat_data", o_dat_data, base + 64'(outcnt));
        check_eq("dat_last", 64'(o_dat_last), 64'(outcnt == int'(len)));
        if (outcnt == 0) out0_cyc = cyc;
        outl_cyc = cyc;
        outcnt++;
      end
      if (i_rvalid && o_rready) begin
        if (k == 0) r0_cyc = cyc;
        exp_err[1:0] = exp_err[1:0] | i_rresp;
        if (i_rlast != (k == int'(len))) exp_err[2] = 1'b1;
        k++;
      end
      if (o_done) begin
        got_done = 1; done_cyc = cyc;
        check_eq("done_err", 64'(o_err), 64'(exp_err));
        check_eq("done_beats", 64'(outcnt), 64'(int'(len) + 1));
        check_eq("done_req_ready", 64'(o_req_ready), 64'd0);
      end
      if (abort_after > 0 && outcnt == abort_after) aborted = 1;
    end
    if (aborted) return;
    check_eq("done_seen", 64'(got_done), 64'd1);
    @(negedge clk);
    i_req_valid = 0; i_arready = 0; i_rvalid = 0; i_rlast = 0; i_dat_ready = 0;
    #1;
    check_eq("req_ready_after_done", 64'(o_req_ready), 64'd1);
    check_eq("done_one_cycle", 64'(o_done), 64'd0);
    check_eq("ar_wait", 64'(ar_cyc - req_cyc), 64'(ar_delay + 1));
    if (!toggle) check_eq("sustained_rate", 64'(outl_cyc - out0_cyc), 64'(len));
    if (chk_timing) begin
      check_eq("lat_r", 64'(r0_cyc - req_cyc), 64'd2);
      check_eq("lat_data", 64'(out0_cyc - req_cyc), 64'd3);
      check_eq("lat_done", 64'(done_cyc - req_cyc), 64'd4);
    end
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("req_ready_at_release", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    #1;
    check_eq("req_ready_first_clk", 64'(o_req_ready), 64'd1);

    // len 0 with everything immediate: minimum latency path
    run_burst(8'h10, 8'd0, 2'b01, 0, 0, -1, 2'b00, -1, 64'hA5A5_0000_0000_0000, 0, 1);
    // plain INCR, data 0..3
    run_burst(8'h00, 8'd3, 2'b01, 0, 0, -1, 2'b00, -1, 64'd0, 0, 0);
    // consumer backpressure; reserved burst code must go out as INCR
    run_burst(8'h40, 8'd7, 2'b11, 0, 1, -1, 2'b00, -1, 64'h1000, 0, 0);
    // slow arready, WRAP burst
    run_burst(8'h20, 8'd3, 2'b10, 5, 0, -1, 2'b00, -1, 64'h2000, 0, 0);
    // SLVERR on beat 1
    run_burst(8'h08, 8'd3, 2'b01, 0, 0, 1, 2'b10, -1, 64'h3000, 0, 0);
    // rlast raised early on beat 2
    run_burst(8'h08, 8'd3, 2'b01, 0, 0, -1, 2'b00, 2, 64'h4000, 0, 0);

    // reset in the middle of DATA after two beats
    run_burst(8'h80, 8'd7, 2'b01, 0, 0, -1, 2'b00, -1, 64'h5000, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    i_req_valid = 0; i_arready = 0; i_rvalid = 0; i_rlast = 0; i_dat_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("req_ready_after_midreset", 64'(o_req_ready), 64'd1);
    run_burst(8'h30, 8'd0, 2'b01, 0, 0, -1, 2'b00, -1, 64'h6000, 0, 1);

`ifdef SRAM_AXI4_RD_MASTER_TIMEOUT_EN
    begin : timeout_run
      bit sent, seen_last;
      int ar_c, d_c;
      sent = 0; seen_last = 0; ar_c = -1; d_c = -1;
      i_req_addr = 8'h00; i_req_len = 8'd3; i_req_burst = 2'b01;
      i_arready = 1; i_rvalid = 0; i_dat_ready = 1;
      for (int c = 0; c < 100 && d_c < 0; c++) begin
        @(negedge clk);
        i_req_valid = !sent;
        #1;
        if (i_req_valid && o_req_ready) sent = 1;
        if (o_arvalid && i_arready) ar_c = c;
        if (o_dat_last) seen_last = 1;
        if (o_done) begin
          d_c = c;
          check_eq("to_err", 64'(o_err), 64'b100);
        end
      end
      check_eq("to_done_seen", 64'(d_c >= 0), 64'd1);
      check_eq("to_latency", 64'(d_c - ar_c), 64'd16);
      check_eq("to_no_last", 64'(seen_last), 64'd0);
      i_rvalid = 1;
      repeat (2) begin
        @(negedge clk);
        #1;
        check_eq("to_rready_low", 64'(o_rready), 64'd0);
      end
      i_rvalid = 0; i_arready = 0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
